ex_hilo: RTL and testbench
==========================

EX_HILO -- requirements
Module: ex_hilo

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, asynchronous active-high reset: rst==1 resets immediately, independent of clk.
REQ-003 SHALL have aluop_i, input, `AluOpBus, operation from decode.
REQ-004 SHALL have alusel_i, input, `AluSelBus, result class (`EXE_RES_LOGIC/_SHIFT/_MOVE/_NOP).
REQ-005 SHALL have reg1_i, input, `RegBus, source operand 1 (shift: amount in [4:0]).
REQ-006 SHALL have reg2_i, input, `RegBus, source operand 2 (shift: data).
REQ-007 SHALL have wd_i, input, `RegAddrBus, and wreg_i, input, 1: destination address and write enable.
REQ-008 SHALL have stall_i, input, 1, downstream hold request.
REQ-009 SHALL have ex_wreg_o, output, 1; ex_wd_o, output, `RegAddrBus; ex_wdata_o, output, `RegBus: combinational forwarding of the current EX result to decode.
REQ-010 SHALL have wreg_o, output, 1; wd_o, output, `RegAddrBus; wdata_o, output, `RegBus: registered stage outputs to the memory stage.
REQ-011 SHALL have hi_o, output, `RegBus, and lo_o, output, `RegBus: committed HI/LO values.

Function
REQ-012 SHALL compute logic results by aluop: `EXE_OR_OP a|b, `EXE_AND_OP a&b, `EXE_XOR_OP a^b, `EXE_NOR_OP ~(a|b), `EXE_NOP_OP 0.
REQ-013 SHALL compute shift results: `EXE_SLL_OP reg2<<reg1[4:0], `EXE_SRL_OP logical right, `EXE_SRA_OP arithmetic right (sign fill); reg1_i[31:5] ignored.
REQ-014 SHALL compute move results: `EXE_MFHI_OP effective HI, `EXE_MFLO_OP effective LO, `EXE_MOVN_OP/`EXE_MOVZ_OP reg1_i.
REQ-015 SHALL select ex_wdata_o by alusel_i; `EXE_RES_NOP or unknown alusel gives `ZeroWord; ex_wreg_o=wreg_i, ex_wd_o=wd_i, all combinational, zero latency.
REQ-016 SHALL, when stall_i==0, load ex_wreg_o/ex_wd_o/ex_wdata_o into wreg_o/wd_o/wdata_o at the rising edge (1-cycle latency); when stall_i==1, hold all stage registers.
REQ-017 SHALL carry a pending HI/LO write in the stage register: hilo_we (1), hilo_sel (0=LO,1=HI), hilo_data (=reg1_i) loaded from `EXE_MTHI_OP/`EXE_MTLO_OP under REQ-016 rules; other ops load hilo_we=0.
REQ-018 SHALL commit pending write to HI or LO at the rising edge where hilo_we==1 and stall_i==0, one cycle after the stage register captures it.
REQ-019 SHALL, under stall_i==1, neither commit nor discard the pending write; it commits on the first non-stalled edge.
REQ-020 SHALL never write HI and LO at the same edge; MTHI followed by MTLO commits on consecutive edges.
REQ-021 SHALL keep wreg_o=0 for MTHI/MTLO regardless of wreg_i; wd_o/wdata_o still registered.
REQ-022 SHALL define effective HI/LO per REQ-029/REQ-030; hi_o/lo_o always show committed values only.

Reset
REQ-023 SHALL, while rst==1, force wreg_o=`WriteDisable, wd_o=`NOPRegAddr, wdata_o=`ZeroWord, hilo_we=0, HI=LO=`ZeroWord.
REQ-024 SHALL drop a pending HI/LO write when rst asserts mid-operation; no commit follows reset release.
REQ-025 SHALL drive ex_wreg_o=0, ex_wd_o=`NOPRegAddr, ex_wdata_o=`ZeroWord while rst==1.
REQ-026 SHALL resume normal capture at the first rising edge with rst==0.

Configuration
REQ-027 SHALL use macro HILO_BYPASS_EN to select HI/LO read bypass.
REQ-028 SHALL, with HILO_BYPASS_EN defined, add no ports and no cycles of latency.
REQ-029 SHALL, with HILO_BYPASS_EN defined, return hilo_data for MFHI/MFLO when a pending write targets the same register, else the committed value.
REQ-030 SHALL, without HILO_BYPASS_EN, return committed HI/LO only; MFHI/MFLO right after MTHI/MTLO reads the old value.

Verification
REQ-031 SHALL test logic path: OR, reg1=0x0000F0F0, reg2=0x00FF0000, wd=5, wreg=1 -> ex_wdata_o=0x00FFF0F0 same cycle; wdata_o=0x00FFF0F0, wd_o=5, wreg_o=1 next edge.
REQ-032 SHALL test shifts: SRA, reg1=4, reg2=0x80000000 -> 0xF8000000; SRL same inputs -> 0x08000000; SLL reg1=0x21 -> amount 1.
REQ-033 SHALL test HI bypass: MTHI reg1=0x12345678 then MFHI next cycle -> 0x12345678 with HILO_BYPASS_EN, 0x00000000 without; hi_o=0x12345678 after second edge in both.
REQ-034 SHALL test stall: MTLO 0xA5A5A5A5 captured, stall_i=1 for 3 cycles -> lo_o stays 0, wdata_o held; stall_i=0 -> lo_o=0xA5A5A5A5 after next edge.
REQ-035 SHALL test reset: rst=1 mid-clock with pending MTHI 0xFFFFFFFF -> all outputs zero immediately; after release hi_o remains 0.

Source files
------------

// File: rtl/ex_hilo.sv
// Execute stage with registered EX/MEM outputs and HI/LO special registers.
// Optional macro HILO_BYPASS_EN: MFHI/MFLO read a pending HI/LO write instead of the committed value.
`ifndef AluOpBus
`define AluOpBus      7:0
`define AluSelBus     2:0
`define RegBus        31:0
`define RegAddrBus    4:0
`define ZeroWord      32'h0000_0000
`define NOPRegAddr    5'b00000
`define WriteDisable  1'b0
`define EXE_NOP_OP    8'b00000000
`define EXE_AND_OP    8'b00100100
`define EXE_OR_OP     8'b00100101
`define EXE_XOR_OP    8'b00100110
`define EXE_NOR_OP    8'b00100111
`define EXE_SLL_OP    8'b01111100
`define EXE_SRL_OP    8'b00000010
`define EXE_SRA_OP    8'b00000011
`define EXE_MOVZ_OP   8'b00001010
`define EXE_MOVN_OP   8'b00001011
`define EXE_MFHI_OP   8'b00010000
`define EXE_MTHI_OP   8'b00010001
`define EXE_MFLO_OP   8'b00010010
`define EXE_MTLO_OP   8'b00010011
`define EXE_RES_NOP   3'b000
`define EXE_RES_LOGIC 3'b001
`define EXE_RES_SHIFT 3'b010
`define EXE_RES_MOVE  3'b011
`endif

module ex_hilo (
  input  logic               clk,
  input  logic               rst,
  input  logic [`AluOpBus]   aluop_i,
  input  logic [`AluSelBus]  alusel_i,
  input  logic [`RegBus]     reg1_i,
  input  logic [`RegBus]     reg2_i,
  input  logic [`RegAddrBus] wd_i,
  input  logic               wreg_i,
  input  logic               stall_i,
  output logic               ex_wreg_o,
  output logic [`RegAddrBus] ex_wd_o,
  output logic [`RegBus]     ex_wdata_o,
  output logic               wreg_o,
  output logic [`RegAddrBus] wd_o,
  output logic [`RegBus]     wdata_o,
  output logic [`RegBus]     hi_o,
  output logic [`RegBus]     lo_o
);

  logic               r_wreg;
  logic [`RegAddrBus] r_wd;
  logic [`RegBus]     r_wdata;
  logic               r_hilo_we;
  logic               r_hilo_sel;
  logic [`RegBus]     r_hilo_data;
  logic [`RegBus]     r_hi;
  logic [`RegBus]     r_lo;

  logic [`RegBus]     w_logic_res;
  logic [`RegBus]     w_shift_res;
  logic [`RegBus]     w_move_res;
  logic [`RegBus]     w_hi_eff;
  logic [`RegBus]     w_lo_eff;
  logic [4:0]         w_shamt;
  logic               w_is_mthi;
  logic               w_is_mtlo;
  logic               w_is_mt;

  assign w_shamt   = reg1_i[4:0];
  assign w_is_mthi = (aluop_i == `EXE_MTHI_OP);
  assign w_is_mtlo = (aluop_i == `EXE_MTLO_OP);
  assign w_is_mt   = w_is_mthi | w_is_mtlo;

`ifdef HILO_BYPASS_EN
  assign w_hi_eff = (r_hilo_we &&  r_hilo_sel) ? r_hilo_data : r_hi;
  assign w_lo_eff = (r_hilo_we && !r_hilo_sel) ? r_hilo_data : r_lo;
`else
  assign w_hi_eff = r_hi;
  assign w_lo_eff = r_lo;
`endif

  always_comb begin
    w_logic_res = `ZeroWord;
    case (aluop_i)
      `EXE_OR_OP:  w_logic_res = reg1_i | reg2_i;
      `EXE_AND_OP: w_logic_res = reg1_i & reg2_i;
      `EXE_XOR_OP: w_logic_res = reg1_i ^ reg2_i;
      `EXE_NOR_OP: w_logic_res = ~(reg1_i | reg2_i);
      default:     w_logic_res = `ZeroWord;
    endcase
  end

  always_comb begin
    w_shift_res = `ZeroWord;
    case (aluop_i)
      `EXE_SLL_OP: w_shift_res = reg2_i << w_shamt;
      `EXE_SRL_OP: w_shift_res = reg2_i >> w_shamt;
      `EXE_SRA_OP: w_shift_res = $unsigned($signed(reg2_i) >>> w_shamt);
      default:     w_shift_res = `ZeroWord;
    endcase
  end

  always_comb begin
    w_move_res = `ZeroWord;
    case (aluop_i)
      `EXE_MFHI_OP: w_move_res = w_hi_eff;
      `EXE_MFLO_OP: w_move_res = w_lo_eff;
      `EXE_MOVN_OP: w_move_res = reg1_i;
      `EXE_MOVZ_OP: w_move_res = reg1_i;
      default:      w_move_res = `ZeroWord;
    endcase
  end

  // Forwarding path to decode; forced quiet while reset is held.
  always_comb begin
    ex_wreg_o  = `WriteDisable;
    ex_wd_o    = `NOPRegAddr;
    ex_wdata_o = `ZeroWord;
    if (!rst) begin
      ex_wreg_o = wreg_i;
      ex_wd_o   = wd_i;
      case (alusel_i)
        `EXE_RES_LOGIC: ex_wdata_o = w_logic_res;
        `EXE_RES_SHIFT: ex_wdata_o = w_shift_res;
        `EXE_RES_MOVE:  ex_wdata_o = w_move_res;
        default:        ex_wdata_o = `ZeroWord;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wreg      <= `WriteDisable;
      r_wd        <= `NOPRegAddr;
      r_wdata     <= `ZeroWord;
      r_hilo_we   <= 1'b0;
      r_hilo_sel  <= 1'b0;
      r_hilo_data <= `ZeroWord;
    end else if (!stall_i) begin
      r_wreg      <= ex_wreg_o & ~w_is_mt;
      r_wd        <= ex_wd_o;
      r_wdata     <= ex_wdata_o;
      r_hilo_we   <= w_is_mt;
      r_hilo_sel  <= w_is_mthi;
      r_hilo_data <= reg1_i;
    end
  end

  // The pending write leaves the stage register on the same edge it commits,
  // so back-to-back MTHI/MTLO land on consecutive edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= `ZeroWord;
      r_lo <= `ZeroWord;
    end else if (!stall_i && r_hilo_we) begin
      if (r_hilo_sel) r_hi <= r_hilo_data;
      else            r_lo <= r_hilo_data;
    end
  end

  assign wreg_o  = r_wreg;
  assign wd_o    = r_wd;
  assign wdata_o = r_wdata;
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;

endmodule

// File: tb/tb_ex_hilo.sv
// Directed-vector bench for ex_hilo; expected values hand-computed.
// Honours HILO_BYPASS_EN for the MFHI/MFLO-after-MTxx expectations.
module tb_ex_hilo;

  localparam logic [7:0] OP_NOP  = 8'b00000000;
  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_MOVN = 8'b00001011;
  localparam logic [7:0] OP_MFHI = 8'b00010000;
  localparam logic [7:0] OP_MTHI = 8'b00010001;
  localparam logic [7:0] OP_MFLO = 8'b00010010;
  localparam logic [7:0] OP_MTLO = 8'b00010011;
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

`ifdef HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, stall_i;
  logic        ex_wreg_o, wreg_o;
  logic [4:0]  ex_wd_o, wd_o;
  logic [31:0] ex_wdata_o, wdata_o, hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_hilo dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .stall_i(stall_i), .ex_wreg_o(ex_wreg_o), .ex_wd_o(ex_wd_o),
    .ex_wdata_o(ex_wdata_o), .wreg_o(wreg_o), .wd_o(wd_o),
    .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic we);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = we;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0;
    drive(OP_OR, SEL_LOGIC, 32'h1, 32'h2, 5'd9, 1'b1);
    step();
    chk("rst_wreg",  {31'd0, wreg_o}, 32'd0);
    chk("rst_wd",    {27'd0, wd_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_hi",    hi_o, 32'd0);
    chk("rst_lo",    lo_o, 32'd0);
    chk("rst_exw",   {31'd0, ex_wreg_o}, 32'd0);
    chk("rst_exd",   ex_wdata_o, 32'd0);
    @(negedge clk); rst = 1'b0;

    drive(OP_OR, SEL_LOGIC, 32'h0000F0F0, 32'h00FF0000, 5'd5, 1'b1);
    chk("or_ex",    ex_wdata_o, 32'h00FFF0F0);
    chk("or_exwd",  {27'd0, ex_wd_o}, 32'd5);
    chk("or_exwr",  {31'd0, ex_wreg_o}, 32'd1);
    chk("or_pre",   wdata_o, 32'd0);
    step();
    chk("or_wdata", wdata_o, 32'h00FFF0F0);
    chk("or_wd",    {27'd0, wd_o}, 32'd5);
    chk("or_wreg",  {31'd0, wreg_o}, 32'd1);

    drive(OP_AND, SEL_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 5'd1, 1'b1);
    chk("and", ex_wdata_o, 32'h0F000F00);
    drive(OP_XOR, SEL_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 5'd1, 1'b1);
    chk("xor", ex_wdata_o, 32'hF00FF00F);
    drive(OP_NOR, SEL_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 5'd1, 1'b1);
    chk("nor", ex_wdata_o, 32'h00F000F0);
    drive(OP_NOP, SEL_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 5'd1, 1'b1);
    chk("lnop", ex_wdata_o, 32'h0);
    drive(OP_SRA, SEL_SHIFT, 32'd4, 32'h80000000, 5'd2, 1'b1);
    chk("sra", ex_wdata_o, 32'hF8000000);
    drive(OP_SRL, SEL_SHIFT, 32'd4, 32'h80000000, 5'd2, 1'b1);
    chk("srl", ex_wdata_o, 32'h08000000);
    drive(OP_SLL, SEL_SHIFT, 32'h21, 32'h00000001, 5'd2, 1'b1);
    chk("sll", ex_wdata_o, 32'h00000002);
    drive(OP_SRA, SEL_SHIFT, 32'hFFFFFFE3, 32'h70000000, 5'd2, 1'b1);
    chk("sra_pos", ex_wdata_o, 32'h0E000000);
    drive(OP_MOVN, SEL_MOVE, 32'hCAFEBABE, 32'h1, 5'd2, 1'b1);
    chk("movn", ex_wdata_o, 32'hCAFEBABE);
    drive(OP_OR, 3'b111, 32'hFFFF, 32'h1, 5'd2, 1'b1);
    chk("badsel", ex_wdata_o, 32'h0);
    drive(OP_OR, SEL_NOP, 32'hFFFF, 32'h1, 5'd2, 1'b1);
    chk("nopsel", ex_wdata_o, 32'h0);

    // HI bypass
    drive(OP_MTHI, SEL_NOP, 32'h12345678, 32'h0, 5'd3, 1'b1);
    step();
    chk("mthi_wreg", {31'd0, wreg_o}, 32'd0);
    chk("mthi_wd",   {27'd0, wd_o}, 32'd3);
    chk("mthi_hi0",  hi_o, 32'd0);
    drive(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd4, 1'b1);
    chk("mfhi_ex", ex_wdata_o, BYP ? 32'h12345678 : 32'h0);
    step();
    chk("mfhi_wdata", wdata_o, BYP ? 32'h12345678 : 32'h0);
    chk("hi_commit", hi_o, 32'h12345678);
    chk("lo_untouched", lo_o, 32'h0);

    // Stall holding a pending LO write
    drive(OP_MTLO, SEL_NOP, 32'hA5A5A5A5, 32'h0, 5'd7, 1'b1);
    step();
    stall_i = 1'b1;
    drive(OP_OR, SEL_LOGIC, 32'h1111, 32'h2222, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_lo",    lo_o, 32'h0);
      chk("stall_wdata", wdata_o, 32'h0);
      chk("stall_wd",    {27'd0, wd_o}, 32'd7);
      chk("stall_wreg",  {31'd0, wreg_o}, 32'd0);
    end
    stall_i = 1'b0;
    drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    chk("unstall_lo", lo_o, 32'hA5A5A5A5);
    chk("unstall_wd", {27'd0, wd_o}, 32'd0);
    chk("unstall_hi", hi_o, 32'h12345678);

    // MTHI then MTLO back-to-back
    drive(OP_MTHI, SEL_NOP, 32'h11111111, 32'h0, 5'd0, 1'b0);
    step();
    drive(OP_MTLO, SEL_NOP, 32'h22222222, 32'h0, 5'd0, 1'b0);
    step();
    chk("b2b_hi", hi_o, 32'h11111111);
    chk("b2b_lo_old", lo_o, 32'hA5A5A5A5);
    drive(OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 5'd6, 1'b1);
    chk("mflo_ex", ex_wdata_o, BYP ? 32'h22222222 : 32'hA5A5A5A5);
    step();
    chk("b2b_lo", lo_o, 32'h22222222);
    chk("b2b_hi2", hi_o, 32'h11111111);
    drive(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd6, 1'b1);
    chk("mfhi_comm", ex_wdata_o, 32'h11111111);
    drive(OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 5'd6, 1'b1);
    chk("mflo_comm", ex_wdata_o, 32'h22222222);

    // Async reset with a pending MTHI
    drive(OP_MTHI, SEL_NOP, 32'hFFFFFFFF, 32'h0, 5'd8, 1'b1);
    step();
    drive(OP_OR, SEL_LOGIC, 32'hF0, 32'h0F, 5'd8, 1'b1);
    step();
    chk("pre_rst_wdata", wdata_o, 32'h000000FF);
    drive(OP_MTHI, SEL_NOP, 32'hFFFFFFFF, 32'h0, 5'd8, 1'b1);
    step();
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_wreg",  {31'd0, wreg_o}, 32'd0);
    chk("arst_wd",    {27'd0, wd_o}, 32'd0);
    chk("arst_wdata", wdata_o, 32'd0);
    chk("arst_hi",    hi_o, 32'd0);
    chk("arst_lo",    lo_o, 32'd0);
    chk("arst_exwr",  {31'd0, ex_wreg_o}, 32'd0);
    chk("arst_exwd",  {27'd0, ex_wd_o}, 32'd0);
    step();
    @(negedge clk); rst = 1'b0;
    drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    step();
    chk("post_rst_hi", hi_o, 32'd0);
    chk("post_rst_lo", lo_o, 32'd0);
    drive(OP_XOR, SEL_LOGIC, 32'h0000FFFF, 32'h00FF00FF, 5'd12, 1'b1);
    step();
    chk("resume_wdata", wdata_o, 32'h00FFFF00);
    chk("resume_wd",    {27'd0, wd_o}, 32'd12);
    chk("resume_wreg",  {31'd0, wreg_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
